execute_stage: RTL

- EX stage of the 5-stage MIPS pipeline, directly downstream of the forwarding unit.
- Consumes ForwardA/ForwardB to select operands, then runs the ALU.
- Contains an iterative unsigned multiplier writing HI/LO, and registers results into the EX/MEM pipeline register.
- Drives EX_busy so hazard/stall logic can hold IF/ID/ID_EX during multiply interlocks or downstream stalls.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/multu_iter.sv | 81 ++++++++
 rtl/execute_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute stage: ALU operation codes,
// forwarding-select encodings and the multiplier state type.
package mips_pkg;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_MULTU = 4'd8;
  localparam logic [3:0] ALU_MFHI  = 4'd9;
  localparam logic [3:0] ALU_MFLO  = 4'd10;
  localparam logic [3:0] ALU_NOR   = 4'd12;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } mul_state_t;

  // Operations that touch HI/LO and therefore must wait for a running multiply.
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == ALU_MULTU) || (op == ALU_MFHI) || (op == ALU_MFLO);
  endfunction

endpackage

// File: rtl/multu_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// DATA_W cycles per product. 'done' marks the final cycle, during which
// 'product' already carries the completed result.
module multu_iter
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  mul_state_t            state_reg;
  mul_state_t            state_next;
  logic [CNT_W-1:0]      count_reg;
  logic [2*DATA_W-1:0]   mcand_reg;
  logic [2*DATA_W-1:0]   acc_reg;
  logic [2*DATA_W-1:0]   acc_next;
  logic [DATA_W-1:0]     mplier_reg;

  // Partial-product accumulation for the current multiplier bit.
  always_comb begin
    acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (count_reg == CNT_W'(1)) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  assign product = acc_next;

  // State register and shift-add datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE) begin
        if (start) begin
          mcand_reg  <= {{DATA_W{1'b0}}, a};
          mplier_reg <= b;
          acc_reg    <= '0;
          count_reg  <= CNT_W'(DATA_W);
        end
      end else begin
        acc_reg    <= acc_next;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        count_reg  <= count_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage: forwarding muxes, ALU, HI/LO with an iterative multiplier,
// and the EX/MEM pipeline register. EX_busy tells upstream to hold ID/EX.
module execute_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ID_EX_valid,
  input  logic [DATA_W-1:0]     ID_EX_ReadData1,
  input  logic [DATA_W-1:0]     ID_EX_ReadData2,
  input  logic [DATA_W-1:0]     ID_EX_Imm,
  input  logic                  ID_EX_ALUSrc,
  input  logic [3:0]            ID_EX_ALUOp,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRd,
  input  logic                  ID_EX_RegWrite,
  input  logic                  ID_EX_MemRead,
  input  logic                  ID_EX_MemWrite,
  input  logic                  ID_EX_MemtoReg,
  input  logic [1:0]            ForwardA,
  input  logic [1:0]            ForwardB,
  input  logic [DATA_W-1:0]     MEM_WB_WriteData,
  input  logic                  MEM_stall,
  input  logic                  flush,
  output logic                  EX_busy,
  output logic                  EX_MEM_valid,
  output logic [DATA_W-1:0]     EX_MEM_ALUResult,
  output logic [DATA_W-1:0]     EX_MEM_WriteData,
  output logic [REG_ADDR_W-1:0] EX_MEM_RegisterRd,
  output logic                  EX_MEM_RegWrite,
  output logic                  EX_MEM_MemRead,
  output logic                  EX_MEM_MemWrite,
  output logic                  EX_MEM_MemtoReg,
  output logic                  EX_MEM_Zero
);

  logic [DATA_W-1:0]   fwd_a;
  logic [DATA_W-1:0]   fwd_b;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_result;
  logic [DATA_W-1:0]   hi_reg;
  logic [DATA_W-1:0]   lo_reg;
  logic                mul_busy;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;
  logic                interlock;
  logic                accept;
  logic                is_multu;

  // Operand forwarding; select 11 falls back to the register-file value.
  always_comb begin
    case (ForwardA)
      FWD_MEM: fwd_a = EX_MEM_ALUResult;
      FWD_WB:  fwd_a = MEM_WB_WriteData;
      default: fwd_a = ID_EX_ReadData1;
    endcase
    case (ForwardB)
      FWD_MEM: fwd_b = EX_MEM_ALUResult;
      FWD_WB:  fwd_b = MEM_WB_WriteData;
      default: fwd_b = ID_EX_ReadData2;
    endcase
    alu_b = ID_EX_ALUSrc ? ID_EX_Imm : fwd_b;
  end

  // ALU; MULTU itself produces 0, its product lands in HI/LO later.
  always_comb begin
    case (ID_EX_ALUOp)
      ALU_AND:  alu_result = fwd_a & alu_b;
      ALU_OR:   alu_result = fwd_a | alu_b;
      ALU_ADD:  alu_result = fwd_a + alu_b;
      ALU_SUB:  alu_result = fwd_a - alu_b;
      ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
      ALU_NOR:  alu_result = ~(fwd_a | alu_b);
      ALU_MFHI: alu_result = hi_reg;
      ALU_MFLO: alu_result = lo_reg;
      default:  alu_result = '0;
    endcase
  end

  assign is_multu  = (ID_EX_ALUOp == ALU_MULTU);
  assign interlock = ID_EX_valid && mul_busy && is_mul_op(ID_EX_ALUOp);
  assign EX_busy   = MEM_stall || interlock;
  assign accept    = ID_EX_valid && !flush && !EX_busy;

  multu_iter #(.DATA_W(DATA_W)) u_multu (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && is_multu),
    .a       (fwd_a),
    .b       (fwd_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // HI/LO capture the product at the end of the final multiply cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (mul_done) begin
      {hi_reg, lo_reg} <= mul_product;
    end
  end

  // EX/MEM register: holds under MEM_stall, loads a bubble when nothing is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      EX_MEM_valid      <= 1'b0;
      EX_MEM_ALUResult  <= '0;
      EX_MEM_WriteData  <= '0;
      EX_MEM_RegisterRd <= '0;
      EX_MEM_RegWrite   <= 1'b0;
      EX_MEM_MemRead    <= 1'b0;
      EX_MEM_MemWrite   <= 1'b0;
      EX_MEM_MemtoReg   <= 1'b0;
      EX_MEM_Zero       <= 1'b0;
    end else if (!MEM_stall) begin
      EX_MEM_valid      <= accept;
      EX_MEM_ALUResult  <= alu_result;
      EX_MEM_WriteData  <= fwd_b;
      EX_MEM_RegisterRd <= ID_EX_RegisterRd;
      EX_MEM_RegWrite   <= accept && ID_EX_RegWrite && !is_multu;
      EX_MEM_MemRead    <= accept && ID_EX_MemRead && !is_multu;
      EX_MEM_MemWrite   <= accept && ID_EX_MemWrite && !is_multu;
      EX_MEM_MemtoReg   <= accept && ID_EX_MemtoReg;
      EX_MEM_Zero       <= (alu_result == '0);
    end
  end

endmodule
